width_12to16_arb: RTL and testbench
===================================

Name: width_12to16_arb

Overview:
Two-requester packet arbiter and sequencer in front of the width_12to16 converter. Grants the converter to one 12-bit source per packet (round-robin). Pads every packet to a multiple of 4 input words (48 bits = 3 output words), so the converter's internal 2-bit phase is back at 0 at every packet boundary. It is the sole driver of the converter's din/din_vld/din_vld_last and shares its clk/rst_n.

Parameters:
PAD_VALUE, 12'h000, word inserted during padding
LEN_W, 16, width of per-packet word counter (pkt_len)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
s0_data  in  12  source 0 data
s0_vld  in  1  source 0 word valid
s0_last  in  1  source 0 last word of packet (qualified by s0_vld)
s0_rdy  out  1  source 0 ready
s1_data  in  12  source 1 data
s1_vld  in  1  source 1 word valid
s1_last  in  1  source 1 last word of packet
s1_rdy  out  1  source 1 ready
cvt_din  out  12  to converter din
cvt_din_vld  out  1  to converter din_vld
cvt_din_vld_last  out  1  to converter din_vld_last; marks final emitted word (real or pad)
grant  out  2  one-hot owner of current packet; 0 when idle
busy  out  1  state != IDLE
pkt_len  out  LEN_W  real (unpadded) words accepted in current/last packet

Behaviour:
- Reset (async, rst_n=0): state=IDLE, phase=0, rr_ptr=0 (source 0 preferred next), all outputs 0. Reset mid-packet drops the packet; the converter resets on the same rst_n, so the phases stay aligned.
- States: IDLE, XFER, PAD.
- IDLE: a source is requesting when its s*_vld=1. Only one requesting -> grant it. Both -> grant the source rr_ptr selects. Grant registers and XFER is entered next cycle; no word is accepted in IDLE. rr_ptr is set to the other source at grant time. pkt_len is cleared at grant.
- XFER: s{g}_rdy=1 for the granted source only; the other rdy=0. rdy depends on state/grant only, never on vld. Transfer = vld&rdy.
- On each transfer, next cycle: cvt_din=data, cvt_din_vld=1, phase=phase+1 (2-bit wrap), pkt_len+1 (saturating at all-ones).
- Bubbles (vld=0) are allowed: cvt_din_vld=0 and phase holds.
- Transfer with last=1 and phase==3: cvt_din_vld_last=1 on that word, then go to IDLE (grant=0).
- Transfer with last=1 and phase!=3: go to PAD and drop rdy next cycle.
- PAD: each cycle emits cvt_din=PAD_VALUE with cvt_din_vld=1 and phase+1. The pad word that brings phase to 0 carries cvt_din_vld_last=1, then state goes to IDLE. Pad count = (4 - real_words mod 4) mod 4, and is never 4.
- Latency: source word to cvt_din is 1 cycle. IDLE to first accept is 1 cycle after grant, i.e. a 2-cycle packet-to-packet gap minimum (IDLE plus grant cycle).
- cvt_din holds its last value when cvt_din_vld=0. cvt_din_vld_last is only ever 1 together with cvt_din_vld.
- The non-granted source's vld/last are ignored. A source dropping vld mid-packet keeps the grant; there is no timeout.
- Simultaneous requests in IDLE: round-robin as above. A source requesting continuously cannot be granted twice in a row while the other is requesting.

Optional Feature:
WIDTH_12TO16_ARB_FIXED_PRIO_EN: when defined, arbitration is fixed priority with source 0 always winning on simultaneous requests, and rr_ptr is removed. When undefined, round-robin as specified.

Test Plan:
- Source 0 only, 4-word packet 0x111..0x444, last on word 4 -> cvt_din 111,222,333,444 on consecutive cycles with last on 444, no pad, grant=01 then 00.
- Source 1, 1-word packet 0xABC -> cvt_din ABC,000,000,000; last only on the third 000; pkt_len=1; converter emits dout 0x0ABC,0x0000,0x0000.
- Both vld from reset, 2-word packets each -> source 0 served first then source 1, each padded with 2 words; repeat -> order 0,1,0,1 (fixed-prio build: 0,0,... while s0 keeps requesting).
- Source 0, 6-word packet with s0_vld low for 3 cycles after word 2 -> no cvt_din_vld during gap, phase held, 2 pad words, last on word 8.
- rst_n asserted during PAD of a 5-word packet -> all outputs 0 immediately; after release a 4-word packet passes with no pad and correct dout alignment.
- PAD_VALUE=12'hFFF, 3-word packet -> exactly one pad word 0xFFF carrying cvt_din_vld_last.

Source files
------------

// File: rtl/width_12to16_arb_if.sv
// ---------------------------------------------------------------------------
// width_12to16_arb_if
//   Bundle of the two 12-bit requester channels, the converter-side word
//   stream and the arbiter status signals.
//
//   Requester side (per source N in {0,1}):
//     sN_data[11:0]  word data              sN_vld   word valid
//     sN_last        last word of packet    sN_rdy   arbiter ready
//   Converter side:
//     cvt_din[11:0], cvt_din_vld, cvt_din_vld_last
//   Status:
//     grant[1:0] (one-hot owner, 0 when idle), busy, pkt_len[LEN_W-1:0]
//
//   Modports: slave  - the arbiter itself
//             master - the environment (sources and converter/observer)
// ---------------------------------------------------------------------------
interface width_12to16_arb_if #(
  parameter int LEN_W = 16
);
  logic [11:0]      s0_data;
  logic             s0_vld;
  logic             s0_last;
  logic             s0_rdy;
  logic [11:0]      s1_data;
  logic             s1_vld;
  logic             s1_last;
  logic             s1_rdy;
  logic [11:0]      cvt_din;
  logic             cvt_din_vld;
  logic             cvt_din_vld_last;
  logic [1:0]       grant;
  logic             busy;
  logic [LEN_W-1:0] pkt_len;

  modport slave (
    input  s0_data, s0_vld, s0_last,
    input  s1_data, s1_vld, s1_last,
    output s0_rdy, s1_rdy,
    output cvt_din, cvt_din_vld, cvt_din_vld_last,
    output grant, busy, pkt_len
  );

  modport master (
    output s0_data, s0_vld, s0_last,
    output s1_data, s1_vld, s1_last,
    input  s0_rdy, s1_rdy,
    input  cvt_din, cvt_din_vld, cvt_din_vld_last,
    input  grant, busy, pkt_len
  );
endinterface

// File: rtl/width_12to16_arb.sv
// ---------------------------------------------------------------------------
// width_12to16_arb
//   Two-requester packet arbiter/sequencer feeding the width_12to16
//   converter. One source owns the converter for a whole packet; each packet
//   is padded with PAD_VALUE words up to a multiple of 4 input words so the
//   converter's 2-bit packing phase is 0 at every packet boundary.
//
//   Ports:
//     clk, rst_n  clock, asynchronous active-low reset (shared with converter)
//     bus         width_12to16_arb_if.slave:
//                   s0_*/s1_*  source channels (data, vld, last in; rdy out)
//                   cvt_*      word stream to the converter (registered)
//                   grant      one-hot packet owner, 0 when idle
//                   busy       state != IDLE
//                   pkt_len    real words accepted in current/last packet
//
//   Parameters:
//     PAD_VALUE  word emitted during padding
//     LEN_W      width of pkt_len (saturating)
//
//   Build option:
//     WIDTH_12TO16_ARB_FIXED_PRIO_EN  defined   -> source 0 wins ties
//                                     undefined -> round-robin on ties
// ---------------------------------------------------------------------------
module width_12to16_arb #(
  parameter logic [11:0] PAD_VALUE = 12'h000,
  parameter int          LEN_W     = 16
) (
  input logic               clk,
  input logic               rst_n,
  width_12to16_arb_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    PAD  = 2'd2
  } state_t;

  state_t           state;
  logic [1:0]       phase;      // input words emitted in packet, mod 4
  logic [1:0]       grant;
  logic [11:0]      cvt_din;
  logic             cvt_din_vld;
  logic             cvt_din_vld_last;
  logic [LEN_W-1:0] pkt_len;

  logic             s0_rdy;
  logic             s1_rdy;
  logic             fire;
  logic [11:0]      sel_data;
  logic             sel_last;
  logic             pick1;      // arbitration winner in IDLE is source 1

`ifndef WIDTH_12TO16_ARB_FIXED_PRIO_EN
  logic             rr_ptr;     // source preferred on the next tie
`endif

  // Ready is a pure decode of state and grant, so it never waits on vld.
  assign s0_rdy = (state == XFER) && grant[0];
  assign s1_rdy = (state == XFER) && grant[1];

  // NOTE: every always_comb output gets a value on every path (here by
  // unconditional assignment) so no latch is inferred.
  always_comb begin
    sel_data = grant[1] ? bus.s1_data : bus.s0_data;
    sel_last = grant[1] ? bus.s1_last : bus.s0_last;
    fire     = (s0_rdy && bus.s0_vld) || (s1_rdy && bus.s1_vld);
  end

`ifdef WIDTH_12TO16_ARB_FIXED_PRIO_EN
  // Source 1 only wins when source 0 is not requesting.
  assign pick1 = bus.s1_vld && !bus.s0_vld;
`else
  // On a tie the pointer decides; it always names the source not served last.
  assign pick1 = bus.s1_vld && (!bus.s0_vld || rr_ptr);
`endif

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= IDLE;
      phase            <= 2'd0;
      grant            <= 2'b00;
      cvt_din          <= 12'h000;
      cvt_din_vld      <= 1'b0;
      cvt_din_vld_last <= 1'b0;
      pkt_len          <= '0;
`ifndef WIDTH_12TO16_ARB_FIXED_PRIO_EN
      rr_ptr           <= 1'b0;
`endif
    end else begin
      // Strobes are single-cycle; cvt_din keeps its last value.
      cvt_din_vld      <= 1'b0;
      cvt_din_vld_last <= 1'b0;

      case (state)
        IDLE: begin
          if (bus.s0_vld || bus.s1_vld) begin
            grant   <= pick1 ? 2'b10 : 2'b01;
            pkt_len <= '0;
            state   <= XFER;
`ifndef WIDTH_12TO16_ARB_FIXED_PRIO_EN
            rr_ptr  <= !pick1;
`endif
          end
        end

        XFER: begin
          if (fire) begin
            cvt_din     <= sel_data;
            cvt_din_vld <= 1'b1;
            phase       <= phase + 2'd1;
            if (pkt_len != '1) begin
              pkt_len <= pkt_len + 1'b1;
            end
            if (sel_last) begin
              if (phase == 2'd3) begin
                // Real word already completes a 4-word group: no padding.
                cvt_din_vld_last <= 1'b1;
                grant            <= 2'b00;
                state            <= IDLE;
              end else begin
                state <= PAD;
              end
            end
          end
        end

        PAD: begin
          cvt_din     <= PAD_VALUE;
          cvt_din_vld <= 1'b1;
          phase       <= phase + 2'd1;
          // The pad word that wraps phase back to 0 closes the packet.
          if (phase == 2'd3) begin
            cvt_din_vld_last <= 1'b1;
            grant            <= 2'b00;
            state            <= IDLE;
          end
        end

        default: begin
          state <= IDLE;
          grant <= 2'b00;
        end
      endcase
    end
  end

  assign bus.s0_rdy           = s0_rdy;
  assign bus.s1_rdy           = s1_rdy;
  assign bus.cvt_din          = cvt_din;
  assign bus.cvt_din_vld      = cvt_din_vld;
  assign bus.cvt_din_vld_last = cvt_din_vld_last;
  assign bus.grant            = grant;
  assign bus.busy             = (state != IDLE);
  assign bus.pkt_len          = pkt_len;

endmodule

// File: tb/tb_width_12to16_arb.sv
// ---------------------------------------------------------------------------
// tb_width_12to16_arb
//   Self-checking bench for width_12to16_arb. Sources are fed from word
//   queues by a negedge driver; a negedge monitor records every emitted
//   converter word. Expected streams come from a directed table and from a
//   packet-level model (arbitration order + pad-to-multiple-of-4 rule).
//   A second instance with PAD_VALUE=12'hFFF checks the pad value.
// ---------------------------------------------------------------------------
module tb_width_12to16_arb;
  localparam int LEN_W = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  width_12to16_arb_if #(.LEN_W(LEN_W)) bus ();
  width_12to16_arb_if #(.LEN_W(LEN_W)) busb ();

  width_12to16_arb #(.PAD_VALUE(12'h000), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );
  width_12to16_arb #(.PAD_VALUE(12'hFFF), .LEN_W(LEN_W)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(busb)
  );

  typedef struct { logic [11:0] data; logic last; int gap; } word_t;
  typedef struct { logic [11:0] data; logic last; logic [1:0] grant;
                   logic [LEN_W-1:0] len; int cyc; } rec_t;
  typedef struct { logic [11:0] data; logic last; int len; int dcyc; } exp_t;
  typedef struct { int src; int len; int gap_idx; int gap_len; int pads;
                   logic [11:0] base; logic [11:0] step; } vec_t;

  word_t srcq0[$], srcq1[$];
  rec_t  outq[$], outqb[$];
  exp_t  expq[$];
  word_t rd0[$], rd1[$];   // model copy of every queued word, per source
  int    ln0[$], ln1[$];   // model copy of packet lengths, per source

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int n_orphan_last = 0;
  int n_both_rdy = 0;
  bit fire[2];
  bit loaded[2];
  int gap_left[2];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One negedge step of source s: retire a word taken at the last posedge,
  // then present the head word (after its leading gap) and note whether the
  // coming posedge will take it.
  task automatic step_src(input int s);
    word_t w;
    bit    have;
    logic  rdy;
    logic  vld;
    if (fire[s]) begin
      if (s == 0 && srcq0.size() > 0) void'(srcq0.pop_front());
      if (s == 1 && srcq1.size() > 0) void'(srcq1.pop_front());
      loaded[s] = 1'b0;
    end
    have = (s == 0) ? (srcq0.size() > 0) : (srcq1.size() > 0);
    w = '{data: 12'h000, last: 1'b0, gap: 0};
    if (have) w = (s == 0) ? srcq0[0] : srcq1[0];
    if (!loaded[s] && have) begin
      loaded[s]   = 1'b1;
      gap_left[s] = w.gap;
    end
    vld = loaded[s] && (gap_left[s] == 0);
    if (loaded[s] && gap_left[s] > 0) gap_left[s]--;
    if (s == 0) begin
      bus.s0_vld = vld; bus.s0_data = w.data; bus.s0_last = w.last; rdy = bus.s0_rdy;
    end else begin
      bus.s1_vld = vld; bus.s1_data = w.data; bus.s1_last = w.last; rdy = bus.s1_rdy;
    end
    fire[s] = vld && rdy;
  endtask

  initial begin
    bus.s0_data = '0; bus.s0_vld = 0; bus.s0_last = 0;
    bus.s1_data = '0; bus.s1_vld = 0; bus.s1_last = 0;
    busb.s0_data = '0; busb.s0_vld = 0; busb.s0_last = 0;
    busb.s1_data = '0; busb.s1_vld = 0; busb.s1_last = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst_n) begin
        if (bus.cvt_din_vld)
          outq.push_back('{data: bus.cvt_din, last: bus.cvt_din_vld_last,
                           grant: bus.grant, len: bus.pkt_len, cyc: cyc});
        if (busb.cvt_din_vld)
          outqb.push_back('{data: busb.cvt_din, last: busb.cvt_din_vld_last,
                            grant: busb.grant, len: busb.pkt_len, cyc: cyc});
        if (bus.cvt_din_vld_last && !bus.cvt_din_vld) n_orphan_last++;
        if (busb.cvt_din_vld_last && !busb.cvt_din_vld) n_orphan_last++;
        if (bus.s0_rdy && bus.s1_rdy) n_both_rdy++;
      end
      if (!rst_n) begin
        for (int s = 0; s < 2; s++) begin
          fire[s] = 0; loaded[s] = 0; gap_left[s] = 0;
        end
        bus.s0_vld = 0; bus.s1_vld = 0;
      end else begin
        step_src(0);
        step_src(1);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic assert_reset();
    @(negedge clk);
    rst_n = 1'b0;
    srcq0.delete(); srcq1.delete();
    rd0.delete(); rd1.delete(); ln0.delete(); ln1.delete();
    repeat (2) @(negedge clk);
    outq.delete(); outqb.delete(); expq.delete();
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic add_pkt(input int s, input int n, input logic [11:0] base,
                         input logic [11:0] step, input int gap_idx,
                         input int gap_len, input bit rnd);
    word_t w;
    for (int i = 0; i < n; i++) begin
      w.data = rnd ? 12'($urandom) : 12'(base + 12'(i) * step);
      w.last = (i == n - 1);
      w.gap  = (i == gap_idx) ? gap_len : 0;
      if (rnd && i > 0 && $urandom_range(0, 99) < 30) w.gap = $urandom_range(1, 3);
      if (s == 0) begin srcq0.push_back(w); rd0.push_back(w); end
      else        begin srcq1.push_back(w); rd1.push_back(w); end
    end
    if (s == 0) ln0.push_back(n); else ln1.push_back(n);
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while ((srcq0.size() > 0 || srcq1.size() > 0 || bus.busy) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    check({name, " drain in budget"}, 64'(n < 3000), 64'd1);
  endtask

  task automatic compare_stream(input string name);
    check({name, " word count"}, 64'(outq.size()), 64'(expq.size()));
    for (int i = 0; i < expq.size() && i < outq.size(); i++) begin
      check($sformatf("%s w%0d data", name, i), 64'(outq[i].data), 64'(expq[i].data));
      check($sformatf("%s w%0d last", name, i), 64'(outq[i].last), 64'(expq[i].last));
      if (expq[i].last)
        check($sformatf("%s w%0d pkt_len", name, i), 64'(outq[i].len), 64'(expq[i].len));
      if (expq[i].dcyc >= 0 && i > 0)
        check($sformatf("%s w%0d spacing", name, i),
              64'(outq[i].cyc - outq[i-1].cyc), 64'(expq[i].dcyc));
    end
  endtask

  // Packet-level model: order of service on ties, then words plus
  // (4 - n mod 4) mod 4 pad words, last flag on the final emitted word.
  task automatic build_expected();
    int  i0 = 0, i1 = 0, w0 = 0, w1 = 0, n, pads;
    bit  prefer1 = 0, take1;
    logic [11:0] d;
    expq.delete();
    while (i0 < ln0.size() || i1 < ln1.size()) begin
`ifdef WIDTH_12TO16_ARB_FIXED_PRIO_EN
      take1 = (i0 >= ln0.size());
`else
      take1 = (i0 >= ln0.size()) || (i1 < ln1.size() && prefer1);
`endif
      prefer1 = !take1;
      n    = take1 ? ln1[i1] : ln0[i0];
      pads = (4 - n % 4) % 4;
      for (int k = 0; k < n; k++) begin
        d = take1 ? rd1[w1 + k].data : rd0[w0 + k].data;
        expq.push_back('{data: d, last: (k == n - 1 && pads == 0), len: n, dcyc: -1});
      end
      for (int p = 0; p < pads; p++)
        expq.push_back('{data: 12'h000, last: (p == pads - 1), len: n, dcyc: -1});
      if (take1) begin i1++; w1 += n; end
      else       begin i0++; w0 += n; end
    end
  endtask

  vec_t tbl[8];

  initial begin
    tbl[0] = '{src: 0, len: 4, gap_idx: -1, gap_len: 0, pads: 0, base: 12'h111, step: 12'h111};
    tbl[1] = '{src: 1, len: 1, gap_idx: -1, gap_len: 0, pads: 3, base: 12'hABC, step: 12'h000};
    tbl[2] = '{src: 0, len: 6, gap_idx: 2,  gap_len: 3, pads: 2, base: 12'h010, step: 12'h001};
    tbl[3] = '{src: 1, len: 3, gap_idx: -1, gap_len: 0, pads: 1, base: 12'h123, step: 12'h010};
    tbl[4] = '{src: 0, len: 5, gap_idx: -1, gap_len: 0, pads: 3, base: 12'h800, step: 12'h002};
    tbl[5] = '{src: 1, len: 8, gap_idx: -1, gap_len: 0, pads: 0, base: 12'hF00, step: 12'h011};
    tbl[6] = '{src: 0, len: 2, gap_idx: -1, gap_len: 0, pads: 2, base: 12'h5A5, step: 12'h101};
    tbl[7] = '{src: 1, len: 7, gap_idx: 5,  gap_len: 2, pads: 1, base: 12'h321, step: 12'h003};

    // Reset values.
    repeat (2) @(negedge clk);
    check("reset outputs",
          {bus.cvt_din, bus.cvt_din_vld, bus.cvt_din_vld_last, bus.grant,
           bus.busy, bus.pkt_len, bus.s0_rdy, bus.s1_rdy}, 64'd0);
    release_reset();

    // Directed single-source packets.
    for (int k = 0; k < 8; k++) begin
      string nm;
      vec_t  e;
      e  = tbl[k];
      nm = $sformatf("tbl%0d", k);
      outq.delete(); expq.delete();
      add_pkt(e.src, e.len, e.base, e.step, e.gap_idx, e.gap_len, 1'b0);
      for (int i = 0; i < e.len; i++)
        expq.push_back('{data: 12'(e.base + 12'(i) * e.step),
                         last: (i == e.len - 1 && e.pads == 0), len: e.len,
                         dcyc: (i == 0) ? -1 : ((i == e.gap_idx) ? 1 + e.gap_len : 1)});
      for (int p = 0; p < e.pads; p++)
        expq.push_back('{data: 12'h000, last: (p == e.pads - 1), len: e.len, dcyc: 1});
      wait_drain(nm);
      compare_stream(nm);
      if (outq.size() > 1) begin
        check({nm, " grant during packet"}, 64'(outq[0].grant), 64'(2'b01 << e.src));
        check({nm, " grant after packet"}, 64'(outq[outq.size()-1].grant), 64'd0);
      end
    end

    // Both sources requesting from reset, two 2-word packets each.
    assert_reset();
    add_pkt(0, 2, 12'hA00, 12'h001, -1, 0, 1'b0);
    add_pkt(0, 2, 12'hA10, 12'h001, -1, 0, 1'b0);
    add_pkt(1, 2, 12'hB00, 12'h001, -1, 0, 1'b0);
    add_pkt(1, 2, 12'hB10, 12'h001, -1, 0, 1'b0);
    build_expected();
    release_reset();
    wait_drain("both");
    compare_stream("both");

    // Reset while padding a 5-word packet, then a clean 4-word packet.
    outq.delete(); expq.delete();
    add_pkt(0, 5, 12'h700, 12'h001, -1, 0, 1'b0);
    begin
      int n = 0;
      while (outq.size() < 5 && n < 100) begin @(negedge clk); n++; end
      check("rst-in-pad reach PAD", 64'(n < 100), 64'd1);
    end
    #2 rst_n = 1'b0;
    #1;
    check("rst-in-pad outputs cleared",
          {bus.cvt_din, bus.cvt_din_vld, bus.cvt_din_vld_last, bus.grant,
           bus.busy, bus.pkt_len, bus.s0_rdy, bus.s1_rdy}, 64'd0);
    srcq0.delete(); srcq1.delete(); rd0.delete(); rd1.delete(); ln0.delete(); ln1.delete();
    repeat (2) @(negedge clk);
    outq.delete();
    rst_n = 1'b1;
    add_pkt(0, 4, 12'h901, 12'h001, -1, 0, 1'b0);
    build_expected();
    wait_drain("post-rst");
    compare_stream("post-rst");

    // Randomized packets from both sources against the packet-level model.
    for (int r = 0; r < 3; r++) begin
      assert_reset();
      for (int p = 0; p < 6; p++) begin
        add_pkt(0, $urandom_range(1, 9), 12'h0, 12'h0, -1, 0, 1'b1);
        add_pkt(1, $urandom_range(1, 9), 12'h0, 12'h0, -1, 0, 1'b1);
      end
      build_expected();
      release_reset();
      wait_drain($sformatf("rand%0d", r));
      compare_stream($sformatf("rand%0d", r));
    end

    // PAD_VALUE=FFF instance: 3-word packet gets exactly one FFF pad word.
    outqb.delete();
    for (int i = 0; i < 3; i++) begin
      int n = 0;
      busb.s0_vld  = 1'b1;
      busb.s0_data = 12'(12'h301 + i);
      busb.s0_last = (i == 2);
      while (!busb.s0_rdy && n < 20) begin @(negedge clk); n++; end
      check($sformatf("padb w%0d accepted", i), 64'(n < 20), 64'd1);
      @(negedge clk);
    end
    busb.s0_vld = 1'b0;
    busb.s0_last = 1'b0;
    repeat (6) @(negedge clk);
    check("padb word count", 64'(outqb.size()), 64'd4);
    if (outqb.size() == 4) begin
      check("padb w0", {outqb[0].data, outqb[0].last}, {12'h301, 1'b0});
      check("padb w1", {outqb[1].data, outqb[1].last}, {12'h302, 1'b0});
      check("padb w2", {outqb[2].data, outqb[2].last}, {12'h303, 1'b0});
      check("padb pad", {outqb[3].data, outqb[3].last}, {12'hFFF, 1'b1});
      check("padb pkt_len", 64'(outqb[3].len), 64'd3);
    end

    check("last without vld", 64'(n_orphan_last), 64'd0);
    check("both rdy high", 64'(n_both_rdy), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
